// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues sequential fetches to a synchronous-read instruction memory
// and buffers the returned words with their PCs for decode; redirect flushes and refetches.
module ifetch_queue #(
  parameter int unsigned     PC_W     = 64,
  parameter int unsigned     INSTR_W  = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       enable,
  input  logic                       redirect,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       imem_ren,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]         imem_rdata,
  output logic                       out_valid,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [PC_W-1:0]            out_pc,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);
  localparam logic [CntW:0] Full = (CntW+1)'(DEPTH);

  logic [PC_W-1:0]    fetch_pc_q;
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q;
  logic               inflight_q;
  logic [PC_W-1:0]    inflight_pc_q;

  logic [CntW:0] fill;
  logic          issue, push, pop;

  always_comb begin
    // An in-flight word always has a reserved slot, so issue only while slots remain.
    fill      = {1'b0, count_q} + (CntW+1)'(inflight_q);
    issue     = arst_n & enable & ~redirect & (fill < Full);
    push      = inflight_q & ~redirect;
    out_valid = (count_q != '0);
    pop       = out_valid & out_ready & ~redirect;
    imem_ren  = issue;
    imem_addr = fetch_pc_q;
    out_instr = instr_mem[rd_ptr_q];
    out_pc    = pc_mem[rd_ptr_q];
    occupancy = count_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      fetch_pc_q    <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else begin
      inflight_q <= issue;
      if (issue) inflight_pc_q <= fetch_pc_q;
      if (redirect) begin
        fetch_pc_q <= {redirect_pc[PC_W-1:2], 2'b00};
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
      end else begin
        if (issue) fetch_pc_q <= fetch_pc_q + PC_W'(4);
        if (push) begin
          instr_mem[wr_ptr_q] <= imem_rdata;
          pc_mem[wr_ptr_q]    <= inflight_pc_q;
          wr_ptr_q            <= wr_ptr_q + PtrW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
        if (push && !pop)      count_q <= count_q + CntW'(1);
        else if (pop && !push) count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a memory model returns word = address, and a scoreboard
// of expected PCs is consumed whenever the queue head is expected to be accepted.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        arst_n, arst8_n;
  logic        enable, redirect, out_ready;
  logic [63:0] redirect_pc;
  logic        imem_ren, out_valid;
  logic [63:0] imem_addr, out_pc;
  logic [31:0] imem_rdata = '0, out_instr;
  logic [2:0]  occupancy;

  logic        imem_ren8, out_valid8;
  logic [7:0]  imem_addr8, out_pc8;
  logic [31:0] imem_rdata8 = '0, out_instr8;
  logic [2:0]  occupancy8;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  ifetch_queue dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_ren(imem_ren), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .occupancy(occupancy)
  );

  ifetch_queue #(.PC_W(8), .RESET_PC(8'hF8)) dut8 (
    .clk(clk), .arst_n(arst8_n), .enable(1'b1), .redirect(1'b0),
    .redirect_pc(8'h00), .imem_ren(imem_ren8), .imem_addr(imem_addr8),
    .imem_rdata(imem_rdata8), .out_valid(out_valid8), .out_instr(out_instr8),
    .out_pc(out_pc8), .out_ready(1'b1), .occupancy(occupancy8)
  );

  always @(posedge clk) begin
    if (imem_ren)  imem_rdata  <= imem_addr[31:0];
    if (imem_ren8) imem_rdata8 <= {24'h0, imem_addr8};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic v, input logic [63:0] pc,
                          input logic [31:0] ins);
    logic [63:0] e;
    if (exp_q.size() == 0) e = '1;
    else e = exp_q.pop_front();
    check({tag, "_valid"}, 64'(v), 64'd1);
    check({tag, "_pc"}, pc, e);
    check({tag, "_instr"}, 64'(ins), 64'(e[31:0]));
  endtask

  initial begin
    arst_n = 1'b0; arst8_n = 1'b0;
    enable = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;

    #3;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_instr", 64'(out_instr), 64'd0);
    check("rst_pc", out_pc, 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_ren", 64'(imem_ren), 64'd0);

    // Streaming
    tick();
    arst_n = 1'b1; out_ready = 1'b1;
    #1;
    check("first_ren", 64'(imem_ren), 64'd1);
    check("first_addr", imem_addr, 64'd0);
    for (int i = 0; i < 8; i++) exp_q.push_back(64'(4 * i));
    tick();
    check("stream_lat_valid", 64'(out_valid), 64'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      sb_check("stream", out_valid, out_pc, out_instr);
      tick();
    end

    // enable=0: no issue, in-flight word still captured
    enable = 1'b0; out_ready = 1'b0;
    #1;
    check("dis_ren", 64'(imem_ren), 64'd0);
    tick();
    check("dis_occ", 64'(occupancy), 64'd2);
    check("dis_head", out_pc, 64'd32);

    // Async reset with 2 queued and one in flight
    enable = 1'b1;
    tick();
    arst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_occ", 64'(occupancy), 64'd0);
    check("arst_pc", out_pc, 64'd0);
    check("arst_ren", 64'(imem_ren), 64'd0);
    arst_n = 1'b1;
    #1;
    check("arst_rel_ren", 64'(imem_ren), 64'd1);
    check("arst_rel_addr", imem_addr, 64'd0);
    tick();
    check("arst_lat_valid", 64'(out_valid), 64'd0);
    tick();
    check("arst_first_valid", 64'(out_valid), 64'd1);
    check("arst_first_pc", out_pc, 64'd0);

    // Stall fill then drain
    tick(); tick(); tick();
    check("fill_occ", 64'(occupancy), 64'd4);
    check("fill_ren", 64'(imem_ren), 64'd0);
    check("fill_head", out_pc, 64'd0);
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(64'(4 * i));
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb_check("drain", out_valid, out_pc, out_instr);
      tick();
    end

    // Redirect with 3 queued and one in flight
    out_ready = 1'b0;
    tick();
    check("pre_redir_occ", 64'(occupancy), 64'd3);
    check("pre_redir_ren", 64'(imem_ren), 64'd0);
    redirect = 1'b1; redirect_pc = 64'h103;
    tick();
    redirect = 1'b0;
    check("redir_occ", 64'(occupancy), 64'd0);
    check("redir_valid1", 64'(out_valid), 64'd0);
    #1;
    check("redir_ren", 64'(imem_ren), 64'd1);
    check("redir_addr", imem_addr, 64'h100);
    tick();
    check("redir_valid2", 64'(out_valid), 64'd0);
    tick();
    exp_q.delete();
    exp_q.push_back(64'h100);
    sb_check("redir", out_valid, out_pc, out_instr);

    // Redirect coinciding with a pop
    redirect = 1'b1; redirect_pc = 64'h200; out_ready = 1'b1;
    tick();
    redirect = 1'b0;
    check("redpop_occ", 64'(occupancy), 64'd0);
    check("redpop_valid1", 64'(out_valid), 64'd0);
    tick();
    check("redpop_valid2", 64'(out_valid), 64'd0);
    tick();
    exp_q.push_back(64'h200);
    exp_q.push_back(64'h204);
    sb_check("redpop", out_valid, out_pc, out_instr);
    tick();
    sb_check("redpop", out_valid, out_pc, out_instr);

    // 8-bit PC wrap
    arst8_n = 1'b1;
    tick();
    check("wrap_lat_valid", 64'(out_valid8), 64'd0);
    tick();
    exp_q.delete();
    exp_q.push_back(64'hF8); exp_q.push_back(64'hFC);
    exp_q.push_back(64'h00); exp_q.push_back(64'h04);
    for (int i = 0; i < 4; i++) begin
      sb_check("wrap", out_valid8, 64'(out_pc8), out_instr8);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
